pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline-stage register for the hazard-aware MIPS pipeline, replacing per-stage hand-written boundary registers (D→E, E→M, M→W). Carries a control bundle and a data bundle with a valid bit. Supports stall (hold), flush (bubble insertion), a downstream ready handshake with an optional one-entry skid buffer, and saturating stall/flush event counters for the hazard unit's debug port.

## Interface

Parameters:
- CTRL_W, 8, control bundle width (D→E: regWrite, memToReg, memWrite, aluSrc, regDst, aluControl[2:0])
- DATA_W, 111, data bundle width (D→E: rd1, rd2, signImm, rs, rt, rd)
- SKID, 0, 1 adds a one-entry skid buffer so in_ready is registered
- CNT_W, 16, event counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  flush: insert bubble
- stall  in  1  hold current contents, accept nothing
- in_valid  in  1  upstream entry valid
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- in_ready  out  1  stage accepts an entry this cycle
- out_valid  out  1  output entry valid
- out_ctrl  out  CTRL_W  output control bundle
- out_data  out  DATA_W  output data bundle
- out_ready  in  1  downstream consumes output this cycle
- stall_cnt  out  CNT_W  cycles with stall=1 and clr=0, saturating
- flush_cnt  out  CNT_W  cycles with clr=1, saturating

## Operation

- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Priority per cycle: rst > clr > stall > handshake.
- clr=1: out_valid, out_ctrl, out_data, skid entry all zeroed next edge; incoming entry dropped regardless of in_valid; stall ignored.
- stall=1 (clr=0): in_ready=0; output and skid registers hold; out_ready ignored (no transfer out).
- SKID=0, states EMPTY/FULL:
  - in_ready = ~stall & (~out_valid | out_ready) (combinational through out_ready).
  - Transfer in loads output regs, out_valid=1. Transfer out without transfer in: out_valid=0, ctrl/data cleared to 0.
- SKID=1, states EMPTY/FULL/SKIDFULL:
  - in_ready = ~stall & ~skid_valid (registered only).
  - EMPTY + in → FULL.
  - FULL + in & out → FULL (new entry). FULL + in & ~out_ready → SKIDFULL (entry to skid). FULL + out only → EMPTY.
  - SKIDFULL + out_ready → FULL (skid moves to output). No input accepted in SKIDFULL.
- Invalid output always presents out_ctrl=0 (no spurious regWrite/memWrite downstream).
- Counters: increment by 1 per qualifying cycle, stick at 2^CNT_W-1; cleared only by rst.

## Timing

- Reset: out_valid=0, out_ctrl=0, out_data=0, skid entry invalid and zero, in_ready=0 while rst high, counters 0. Asserted asynchronously; rst release takes effect at next edge (in_ready=~stall thereafter).
- Latency: 1 cycle in→out. Throughput 1/cycle when out_ready held high.
- clr mid-SKIDFULL: both entries lost, EMPTY next cycle.
- clr and stall same cycle: flush taken, flush_cnt++, stall_cnt unchanged.
- out_ready tied 1, SKID=0: exact behaviour of the legacy D→E register (stall=~enable, clr=flush).

## Structure

- Package pipe_pkg: CTRL_W/DATA_W constants per stage boundary (DE, EM, MW); bit offsets of each control and data field in the bundles; state enum {EMPTY, FULL, SKIDFULL}.
- Sub-module pipe_skid_buf (instantiated under SKID=1 generate): one-entry holding register with valid, load, unload, clear.
- Counters inline (two instances of a saturating increment).

## Test plan

- Reset mid-stream: FULL with out_ctrl=8'hA5, assert rst between edges → out_valid=0, out_ctrl=0 immediately, counters 0.
- Streaming, SKID=0, out_ready=1: entries data 1,2,3 on consecutive cycles → out_data 1,2,3 one cycle later, out_valid continuous.
- Stall: FULL with data 7, stall=1 for 3 cycles, in_valid=1 data 9 → out_data stays 7, in_ready=0, stall_cnt=3; data 9 accepted on first cycle after stall drops.
- Flush+stall: stall=1, clr=1 same cycle with data 5 held → next cycle out_valid=0, out_ctrl=0, flush_cnt=1, stall_cnt=0.
- SKID=1 backpressure: out_ready=0, entries 4 then 6 → state SKIDFULL, in_ready=0; raise out_ready → outputs 4 then 6 on consecutive cycles, in_ready=1 the cycle after skid empties.
- Saturation, CNT_W=4: stall held 20 cycles → stall_cnt=15.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the MIPS pipeline boundary registers:
// per-boundary bundle widths, field offsets and the stage state encoding.
package pipe_pkg;

    // D->E boundary
    localparam int unsigned DE_CTRL_W = 8;
    localparam int unsigned DE_DATA_W = 111;
    // E->M boundary: regWrite, memToReg, memWrite / aluOut, writeData, writeReg
    localparam int unsigned EM_CTRL_W = 3;
    localparam int unsigned EM_DATA_W = 69;
    // M->W boundary: regWrite, memToReg / readData, aluOut, writeReg
    localparam int unsigned MW_CTRL_W = 2;
    localparam int unsigned MW_DATA_W = 69;

    // D->E control bit positions
    localparam int unsigned DE_REGWRITE_BIT  = 7;
    localparam int unsigned DE_MEMTOREG_BIT  = 6;
    localparam int unsigned DE_MEMWRITE_BIT  = 5;
    localparam int unsigned DE_ALUSRC_BIT    = 4;
    localparam int unsigned DE_REGDST_BIT    = 3;
    localparam int unsigned DE_ALUCTRL_LSB   = 0;

    // D->E data field LSBs
    localparam int unsigned DE_RD1_LSB       = 79;
    localparam int unsigned DE_RD2_LSB       = 47;
    localparam int unsigned DE_SIGNIMM_LSB   = 15;
    localparam int unsigned DE_RS_LSB        = 10;
    localparam int unsigned DE_RT_LSB        = 5;
    localparam int unsigned DE_RD_LSB        = 0;

    // E->M / M->W field positions
    localparam int unsigned EM_REGWRITE_BIT  = 2;
    localparam int unsigned EM_MEMTOREG_BIT  = 1;
    localparam int unsigned EM_MEMWRITE_BIT  = 0;
    localparam int unsigned EM_ALUOUT_LSB    = 37;
    localparam int unsigned EM_WRITEDATA_LSB = 5;
    localparam int unsigned EM_WRITEREG_LSB  = 0;
    localparam int unsigned MW_REGWRITE_BIT  = 1;
    localparam int unsigned MW_MEMTOREG_BIT  = 0;
    localparam int unsigned MW_READDATA_LSB  = 37;
    localparam int unsigned MW_ALUOUT_LSB    = 5;
    localparam int unsigned MW_WRITEREG_LSB  = 0;

    // D->E control bundle layout
    typedef struct packed {
        logic       regWrite;
        logic       memToReg;
        logic       memWrite;
        logic       aluSrc;
        logic       regDst;
        logic [2:0] aluControl;
    } deCtrl_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FULL     = 2'd1,
        SKIDFULL = 2'd2
    } pipeState_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake and bundle signals of one pipeline stage.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = DE_CTRL_W,
    parameter int unsigned DATA_W = DE_DATA_W
);
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    // Stage side
    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );

    // Environment side: drives the upstream entry and downstream ready
    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_skid_buf.sv
// One-entry holding register; the entry reads as zero whenever it is invalid.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = DE_CTRL_W,
    parameter int unsigned DATA_W = DE_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              unload,
    input  logic [CTRL_W-1:0] loadCtrl,
    input  logic [DATA_W-1:0] loadData,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear || (unload && !load)) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= loadCtrl;
            data  <= loadData;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with stall, flush, ready handshake, optional
// skid entry and saturating stall/flush event counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = DE_CTRL_W,
    parameter int unsigned DATA_W = DE_DATA_W,
    parameter int unsigned SKID   = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             stall,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipeState_t        state, stateN;
    logic              outValid, outValidN;
    logic [CTRL_W-1:0] outCtrl, outCtrlN;
    logic [DATA_W-1:0] outData, outDataN;
    logic              readyQ;
    logic              skidValid;
    logic [CTRL_W-1:0] skidCtrl;
    logic [DATA_W-1:0] skidData;
    logic              inReady, xferIn, xferOut;

    // readyQ holds in_ready low through reset and until the first edge after release
    always_comb begin
        if (SKID != 0) inReady = readyQ & ~stall & ~skidValid;
        else           inReady = readyQ & ~stall & (~outValid | bus.out_ready);
    end

    assign xferIn  = bus.in_valid & inReady & ~clr;
    assign xferOut = outValid & bus.out_ready & ~stall & ~clr;

    always_comb begin
        stateN    = state;
        outValidN = outValid;
        outCtrlN  = outCtrl;
        outDataN  = outData;
        if (clr) begin
            stateN    = EMPTY;
            outValidN = 1'b0;
            outCtrlN  = '0;
            outDataN  = '0;
        end else if (!stall) begin
            unique case (state)
                EMPTY: begin
                    if (xferIn) begin
                        stateN    = FULL;
                        outValidN = 1'b1;
                        outCtrlN  = bus.in_ctrl;
                        outDataN  = bus.in_data;
                    end
                end
                FULL: begin
                    if (xferIn && xferOut) begin
                        outCtrlN = bus.in_ctrl;
                        outDataN = bus.in_data;
                    end else if (xferIn) begin
                        // only reachable with the skid entry present
                        stateN = SKIDFULL;
                    end else if (xferOut) begin
                        stateN    = EMPTY;
                        outValidN = 1'b0;
                        outCtrlN  = '0;
                        outDataN  = '0;
                    end
                end
                SKIDFULL: begin
                    if (bus.out_ready) begin
                        stateN    = FULL;
                        outValidN = 1'b1;
                        outCtrlN  = skidCtrl;
                        outDataN  = skidData;
                    end
                end
                default: begin
                    stateN    = EMPTY;
                    outValidN = 1'b0;
                    outCtrlN  = '0;
                    outDataN  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            outValid <= 1'b0;
            outCtrl  <= '0;
            outData  <= '0;
            readyQ   <= 1'b0;
        end else begin
            state    <= stateN;
            outValid <= outValidN;
            outCtrl  <= outCtrlN;
            outData  <= outDataN;
            readyQ   <= 1'b1;
        end
    end

    generate
        if (SKID != 0) begin : gSkid
            logic skidLoad, skidUnload;
            assign skidLoad   = (state == FULL) & xferIn & ~xferOut;
            assign skidUnload = (state == SKIDFULL) & bus.out_ready & ~stall & ~clr;

            pipe_skid_buf #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) uSkid (
                .clk      (clk),
                .rst      (rst),
                .clear    (clr),
                .load     (skidLoad),
                .unload   (skidUnload),
                .loadCtrl (bus.in_ctrl),
                .loadData (bus.in_data),
                .valid    (skidValid),
                .ctrl     (skidCtrl),
                .data     (skidData)
            );
        end else begin : gNoSkid
            assign skidValid = 1'b0;
            assign skidCtrl  = '0;
            assign skidData  = '0;
        end
    endgenerate

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (clr && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (stall && !clr && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_ctrl  = outCtrl;
    assign bus.out_data  = outData;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: SKID=0 stage, SKID=1 stage and a 4-bit-counter stage.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst;
    logic clr0, stall0, clr1, stall1, clr2, stall2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [3:0]  sc2, fc2;
    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(111)) bus0 ();
    pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(111)) bus1 ();
    pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(111)) bus2 ();

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(111), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .clr(clr0), .stall(stall0), .bus(bus0),
        .stall_cnt(sc0), .flush_cnt(fc0));
    pipe_stage_reg #(.CTRL_W(8), .DATA_W(111), .SKID(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .clr(clr1), .stall(stall1), .bus(bus1),
        .stall_cnt(sc1), .flush_cnt(fc1));
    pipe_stage_reg #(.CTRL_W(8), .DATA_W(111), .SKID(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .clr(clr2), .stall(stall2), .bus(bus2),
        .stall_cnt(sc2), .flush_cnt(fc2));

    task automatic checkVal(input string tag, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        {clr0, stall0, clr1, stall1, clr2, stall2} = '0;
        bus0.in_valid = 1'b0; bus0.in_ctrl = '0; bus0.in_data = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_ctrl = '0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_ctrl = '0; bus2.in_data = '0; bus2.out_ready = 1'b0;

        // Reset state
        step(); step();
        checkVal("rst_out_valid", 128'(bus0.out_valid), 128'(0));
        checkVal("rst_out_ctrl",  128'(bus0.out_ctrl),  128'(0));
        checkVal("rst_out_data",  128'(bus0.out_data),  128'(0));
        checkVal("rst_in_ready",  128'(bus0.in_ready),  128'(0));
        checkVal("rst_stall_cnt", 128'(sc0),            128'(0));
        checkVal("rst_flush_cnt", 128'(fc0),            128'(0));
        rst = 1'b0;
        #1;
        checkVal("rel_in_ready_before_edge", 128'(bus0.in_ready), 128'(0));
        step();
        checkVal("rel_in_ready_after_edge",  128'(bus0.in_ready), 128'(1));
        checkVal("rel_in_ready_skid",        128'(bus1.in_ready), 128'(1));

        // Reset mid-stream
        bus0.in_valid = 1'b1; bus0.in_ctrl = 8'hA5; bus0.in_data = 111'(1);
        step();
        checkVal("mid_out_ctrl",  128'(bus0.out_ctrl),  128'(8'hA5));
        checkVal("mid_out_valid", 128'(bus0.out_valid), 128'(1));
        bus0.in_valid = 1'b0; stall0 = 1'b1;
        step();
        stall0 = 1'b0;
        checkVal("mid_stall_cnt", 128'(sc0), 128'(1));
        #2 rst = 1'b1;
        #1;
        checkVal("async_out_valid", 128'(bus0.out_valid), 128'(0));
        checkVal("async_out_ctrl",  128'(bus0.out_ctrl),  128'(0));
        checkVal("async_stall_cnt", 128'(sc0),            128'(0));
        checkVal("async_in_ready",  128'(bus0.in_ready),  128'(0));
        step();
        rst = 1'b0;
        step();

        // Streaming, out_ready held high
        bus0.out_ready = 1'b1; bus0.in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus0.in_ctrl = 8'(i);
            bus0.in_data = 111'(i);
            step();
            checkVal($sformatf("stream_data%0d", i),  128'(bus0.out_data),  128'(i));
            checkVal($sformatf("stream_valid%0d", i), 128'(bus0.out_valid), 128'(1));
        end
        bus0.in_valid = 1'b0;
        step();
        checkVal("drain_out_valid", 128'(bus0.out_valid), 128'(0));
        checkVal("drain_out_ctrl",  128'(bus0.out_ctrl),  128'(0));
        checkVal("drain_out_data",  128'(bus0.out_data),  128'(0));

        // Stall holds contents for 3 cycles
        bus0.in_valid = 1'b1; bus0.in_ctrl = 8'h07; bus0.in_data = 111'(7);
        step();
        checkVal("stall_load", 128'(bus0.out_data), 128'(7));
        stall0 = 1'b1; bus0.in_ctrl = 8'h09; bus0.in_data = 111'(9);
        #1;
        checkVal("stall_in_ready", 128'(bus0.in_ready), 128'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            checkVal($sformatf("stall_hold%0d", i), 128'(bus0.out_data), 128'(7));
        end
        checkVal("stall_cnt3", 128'(sc0), 128'(3));
        stall0 = 1'b0;
        #1;
        checkVal("unstall_in_ready", 128'(bus0.in_ready), 128'(1));
        step();
        checkVal("unstall_accept", 128'(bus0.out_data), 128'(9));
        bus0.in_valid = 1'b0;
        step();

        // Flush and stall in the same cycle
        bus0.out_ready = 1'b0; bus0.in_valid = 1'b1; bus0.in_ctrl = 8'h5A; bus0.in_data = 111'(5);
        step();
        checkVal("flush_pre_data", 128'(bus0.out_data), 128'(5));
        stall0 = 1'b1; clr0 = 1'b1;
        step();
        checkVal("flush_out_valid", 128'(bus0.out_valid), 128'(0));
        checkVal("flush_out_ctrl",  128'(bus0.out_ctrl),  128'(0));
        checkVal("flush_out_data",  128'(bus0.out_data),  128'(0));
        checkVal("flush_cnt1",      128'(fc0),            128'(1));
        checkVal("flush_stall_cnt", 128'(sc0),            128'(3));
        stall0 = 1'b0; clr0 = 1'b0; bus0.in_valid = 1'b0;

        // SKID=1 backpressure
        bus1.out_ready = 1'b0; bus1.in_valid = 1'b1; bus1.in_ctrl = 8'h44; bus1.in_data = 111'(4);
        step();
        checkVal("skid_first",    128'(bus1.out_data), 128'(4));
        checkVal("skid_ready1",   128'(bus1.in_ready), 128'(1));
        bus1.in_ctrl = 8'h66; bus1.in_data = 111'(6);
        step();
        checkVal("skid_full_out", 128'(bus1.out_data), 128'(4));
        checkVal("skid_full_rdy", 128'(bus1.in_ready), 128'(0));
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
        #1;
        checkVal("skid_out4", 128'(bus1.out_data), 128'(4));
        step();
        checkVal("skid_out6",      128'(bus1.out_data), 128'(6));
        checkVal("skid_out6_ctrl", 128'(bus1.out_ctrl), 128'(8'h66));
        checkVal("skid_rdy_again", 128'(bus1.in_ready), 128'(1));
        step();
        checkVal("skid_empty", 128'(bus1.out_valid), 128'(0));

        // Flush while SKIDFULL drops both entries
        bus1.out_ready = 1'b0; bus1.in_valid = 1'b1; bus1.in_data = 111'(4);
        step();
        bus1.in_data = 111'(6);
        step();
        checkVal("skid2_full_rdy", 128'(bus1.in_ready), 128'(0));
        bus1.in_valid = 1'b0; clr1 = 1'b1;
        step();
        checkVal("skid_clr_valid", 128'(bus1.out_valid), 128'(0));
        checkVal("skid_clr_data",  128'(bus1.out_data),  128'(0));
        checkVal("skid_clr_rdy",   128'(bus1.in_ready),  128'(1));
        checkVal("skid_clr_cnt",   128'(fc1),            128'(1));
        clr1 = 1'b0; bus1.out_ready = 1'b1;
        step();
        checkVal("skid_clr_lost", 128'(bus1.out_valid), 128'(0));

        // Counter saturation with CNT_W=4
        stall2 = 1'b1;
        repeat (10) step();
        checkVal("sat_cnt10", 128'(sc2), 128'(10));
        repeat (10) step();
        checkVal("sat_cnt20", 128'(sc2), 128'(15));
        checkVal("sat_flush", 128'(fc2), 128'(0));
        stall2 = 1'b0;
        step();
        checkVal("sat_hold", 128'(sc2), 128'(15));

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
